// File: rtl/iir_mac_sequencer.sv
// ============================================================================
// Module   : iir_mac_sequencer
// Brief    : Time-multiplexed direct-form-I biquad controller; one shared
//            signed multiplier/accumulator, five tap cycles per sample.
//            Optional macro IIR_SAT_EN saturates the result instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int B0_INIT    = 6,
    parameter int B1_INIT    = 1,
    parameter int B2_INIT    = 2,
    parameter int A1_INIT    = 4,
    parameter int A2_INIT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    state_t                        state_q, state_d;
    logic [2:0]                    tap_q, tap_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]  x_q, x_d, xn1_q, xn1_d, xn2_q, xn2_d;
    logic signed [DATA_WIDTH-1:0]  yn1_q, yn1_d, yn2_q, yn2_d;
    logic signed [DATA_WIDTH-1:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic signed [DATA_WIDTH-1:0]  a1_q, a1_d, a2_q, a2_d;
    logic                          m_valid_q, m_valid_d;
    logic signed [DATA_WIDTH-1:0]  m_data_q, m_data_d;

    logic signed [DATA_WIDTH-1:0]  w_coef, w_opnd;
    logic signed [PROD_WIDTH-1:0]  w_prod;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_acc_next;

`ifdef IIR_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

    function automatic logic signed [DATA_WIDTH-1:0] to_result(
        input logic signed [ACC_WIDTH-1:0] acc
    );
`ifdef IIR_SAT_EN
        if (acc > SAT_MAX)
            to_result = SAT_MAX[DATA_WIDTH-1:0];
        else if (acc < SAT_MIN)
            to_result = SAT_MIN[DATA_WIDTH-1:0];
        else
            to_result = acc[DATA_WIDTH-1:0];
`else
        to_result = acc[DATA_WIDTH-1:0];
`endif
    endfunction

    // Tap order: b0*x, b1*xn1, b2*xn2, a1*yn1, a2*yn2.
    always_comb begin
        w_coef = b0_q;
        w_opnd = x_q;
        case (tap_q)
            3'd0:    begin w_coef = b0_q; w_opnd = x_q;   end
            3'd1:    begin w_coef = b1_q; w_opnd = xn1_q; end
            3'd2:    begin w_coef = b2_q; w_opnd = xn2_q; end
            3'd3:    begin w_coef = a1_q; w_opnd = yn1_q; end
            3'd4:    begin w_coef = a2_q; w_opnd = yn2_q; end
            default: begin w_coef = b0_q; w_opnd = x_q;   end
        endcase
        w_prod     = w_coef * w_opnd;
        w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};
        w_acc_next = (tap_q <= 3'd2) ? (acc_q + w_prod_ext) : (acc_q - w_prod_ext);
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        x_d       = x_q;
        xn1_d     = xn1_q;
        xn2_d     = xn2_q;
        yn1_d     = yn1_q;
        yn2_d     = yn2_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        case (state_q)
            IDLE: begin
                // Coefficients only change between samples, so the write lands
                // before the first tap of a sample accepted in the same cycle.
                if (cfg_we) begin
                    case (cfg_addr)
                        3'd0: b0_d = cfg_wdata;
                        3'd1: b1_d = cfg_wdata;
                        3'd2: b2_d = cfg_wdata;
                        3'd3: a1_d = cfg_wdata;
                        3'd4: a2_d = cfg_wdata;
                        3'd7: begin
                            xn1_d = '0;
                            xn2_d = '0;
                            yn1_d = '0;
                            yn2_d = '0;
                        end
                        default: ;
                    endcase
                end
                if (s_valid) begin
                    x_d     = s_data;
                    acc_d   = '0;
                    tap_d   = 3'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = w_acc_next;
                if (tap_q == 3'd4) begin
                    tap_d     = 3'd0;
                    m_valid_d = 1'b1;
                    m_data_d  = to_result(w_acc_next);
                    state_d   = OUT;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            OUT: begin
                if (m_ready) begin
                    xn2_d     = xn1_q;
                    xn1_d     = x_q;
                    yn2_d     = yn1_q;
                    yn1_d     = m_data_q;
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tap_q     <= 3'd0;
            acc_q     <= '0;
            x_q       <= '0;
            xn1_q     <= '0;
            xn2_q     <= '0;
            yn1_q     <= '0;
            yn2_q     <= '0;
            b0_q      <= DATA_WIDTH'(B0_INIT);
            b1_q      <= DATA_WIDTH'(B1_INIT);
            b2_q      <= DATA_WIDTH'(B2_INIT);
            a1_q      <= DATA_WIDTH'(A1_INIT);
            a2_q      <= DATA_WIDTH'(A2_INIT);
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            xn1_q     <= xn1_d;
            xn2_q     <= xn2_d;
            yn1_q     <= yn1_d;
            yn2_q     <= yn2_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign s_ready = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

`default_nettype wire

// File: tb/tb_iir_mac_sequencer.sv
// ============================================================================
// Module   : tb_iir_mac_sequencer
// Brief    : Directed self-checking bench for iir_mac_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iir_mac_sequencer;

    logic               clk;
    logic               rst_n;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_data;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] m_data;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic signed [15:0] cfg_wdata;
    logic               busy;

    int n_vec;
    int n_err;

    iir_mac_sequencer #(
        .DATA_WIDTH(16),
        .ACC_WIDTH (40),
        .B0_INIT   (6),
        .B1_INIT   (1),
        .B2_INIT   (2),
        .A1_INIT   (4),
        .A2_INIT   (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents x, waits for its accept edge, then returns at the first falling
    // edge where m_valid is seen. lat counts falling edges after the accept.
    task automatic send(input logic signed [15:0] x, output logic signed [15:0] y,
                        output int lat);
        int g;
        g = 0;
        @(negedge clk);
        s_data  = x;
        s_valid = 1'b1;
        while (!s_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        y = m_data;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic signed [15:0] d);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'sd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: s_ready=%b m_valid=%b m_data=%0d busy=%b, want 1 0 0 0",
                     s_ready, m_valid, m_data, busy);
        end
    endtask

    task automatic test_impulse;
        logic signed [15:0] y;
        int lat;
        logic signed [15:0] xs  [4];
        logic signed [15:0] exp_y [4];
        xs    = '{16'sd1, 16'sd0, 16'sd0, 16'sd0};
        exp_y = '{16'sd6, -16'sd23, 16'sd76, -16'sd235};
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(xs[i], y, lat);
            n_vec++;
            if (y !== exp_y[i]) begin
                n_err++;
                $display("FAIL impulse_y%0d: got %0d want %0d", i, y, exp_y[i]);
            end
            n_vec++;
            if (lat != 6) begin
                n_err++;
                $display("FAIL impulse_lat%0d: got %0d want 6", i, lat);
            end
        end
    endtask

    task automatic test_backpressure;
        logic signed [15:0] y;
        int lat;
        cfg_write(3'd7, 16'sd0);
        m_ready = 1'b0;
        send(16'sd1, y, lat);
        n_vec++;
        if (y !== 16'sd6) begin
            n_err++;
            $display("FAIL bp_first: got %0d want 6", y);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (m_data !== 16'sd6 || m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: m_data=%0d m_valid=%b s_ready=%b busy=%b, want 6 1 0 1",
                         i, m_data, m_valid, s_ready, busy);
            end
        end
        m_ready = 1'b1;
        send(16'sd0, y, lat);
        n_vec++;
        if (y !== -16'sd23) begin
            n_err++;
            $display("FAIL bp_next: got %0d want -23", y);
        end
    endtask

    task automatic test_config;
        logic signed [15:0] y;
        int lat;
        int g;
        @(negedge clk);
        cfg_write(3'd0, 16'sd2);
        cfg_write(3'd7, 16'sd0);
        send(16'sd5, y, lat);
        n_vec++;
        if (y !== 16'sd10) begin
            n_err++;
            $display("FAIL cfg_b0: got %0d want 10", y);
        end
        // Sample x=0 with a write to a1 attempted during MAC.
        @(negedge clk);
        s_data  = 16'sd0;
        s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid   = 1'b0;
        cfg_we    = 1'b1;
        cfg_addr  = 3'd3;
        cfg_wdata = 16'sd100;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_busy: got %b want 1", busy);
        end
        @(negedge clk);
        cfg_we = 1'b0;
        g = 0;
        while (!m_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        // y = b1*5 - a1*10 with a1 still 4
        n_vec++;
        if (m_data !== -16'sd35 || m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_dropped: got %0d valid=%b want -35 valid=1", m_data, m_valid);
        end
    endtask

    task automatic test_overflow;
        logic signed [15:0] y;
        int lat;
        @(negedge clk);
        cfg_write(3'd0, 16'sd6);
        cfg_write(3'd7, 16'sd0);
        send(16'sd10000, y, lat);
        n_vec++;
`ifdef IIR_SAT_EN
        if (y !== 16'sd32767) begin
            n_err++;
            $display("FAIL overflow_sat: got %0d want 32767", y);
        end
`else
        if (y !== -16'sd5536) begin
            n_err++;
            $display("FAIL overflow_wrap: got %0d want -5536", y);
        end
`endif
    endtask

    task automatic test_same_cycle_cfg;
        logic signed [15:0] y;
        int lat;
        @(negedge clk);
        cfg_write(3'd7, 16'sd0);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = 3'd0;
        cfg_wdata = 16'sd3;
        s_data    = 16'sd2;
        s_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_we  = 1'b0;
        s_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (m_data !== 16'sd6 || lat != 6) begin
            n_err++;
            $display("FAIL same_cycle_cfg: got %0d lat %0d want 6 lat 6", m_data, lat);
        end
    endtask

    task automatic test_reset_mid;
        logic signed [15:0] y;
        int lat;
        int seen;
        @(negedge clk);
        s_data  = 16'sd7;
        s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'sd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: s_ready=%b m_valid=%b m_data=%0d busy=%b, want 1 0 0 0",
                     s_ready, m_valid, m_data, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_no_partial: m_valid seen=%0d want 0", seen);
        end
        send(16'sd1, y, lat);
        n_vec++;
        if (y !== 16'sd6) begin
            n_err++;
            $display("FAIL reset_y0: got %0d want 6", y);
        end
        send(16'sd0, y, lat);
        n_vec++;
        if (y !== -16'sd23) begin
            n_err++;
            $display("FAIL reset_y1: got %0d want -23", y);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        test_reset;
        test_impulse;
        test_backpressure;
        test_config;
        test_overflow;
        test_same_cycle_cfg;
        test_reset_mid;

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
